// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the shift-add multiplier
//
// Purpose: FSM state encoding and the width helper used to size the
//          iteration counter and the partial-sum bit offset.
// Ports:   none (package).

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Bits needed to hold values 0..n-1; never less than one so that a
  // single-iteration configuration still gets a real counter register.
  function automatic int count_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_partial_sum.sv
// rtl/mult_partial_sum.sv - combinational partial sum for one multiplier step
//
// Purpose: adds up to BITS_PER_CYCLE copies of the multiplicand, each shifted
//          to the weight of the multiplier bit that selects it.
// Ports:
//   bits    in   BITS_PER_CYCLE  multiplier bits retired this step (LSB first)
//   mcand   in   2*WIDTH         zero-extended multiplicand
//   offset  in   OFF_W           weight of bits[0] within the multiplier
//   psum    out  2*WIDTH         sum of selected, shifted multiplicands

module mult_partial_sum
  import mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0]      bits,
  input  logic [2*WIDTH-1:0]             mcand,
  input  logic [count_w(2*WIDTH)-1:0]    offset,
  output logic [2*WIDTH-1:0]             psum
);

  localparam int OFF_W = count_w(2 * WIDTH);

  always_comb begin
    psum = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (bits[k]) begin
        psum = psum + (mcand << (offset + OFF_W'(k)));
      end
    end
  end

endmodule

// File: rtl/multiplier_shift_add_seq.sv
// rtl/multiplier_shift_add_seq.sv - multi-cycle shift-add multiplier with valid/ready
//
// Purpose: multiplies in1 (multiplier) by in2 (multiplicand), retiring
//          BITS_PER_CYCLE multiplier bits per clock. One operation in flight;
//          the product is presented with out_valid exactly WIDTH/BITS_PER_CYCLE
//          cycles after the accepting edge and held until out_ready.
// Optional feature macro: MULT_SIGNED_EN adds the in_signed port; when in_signed
//          is high the operands are two's complement (magnitudes multiplied,
//          product negated on the final step if the signs differ).
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        operands present on in1/in2
//   in_ready   out  1        high only in IDLE
//   in1        in   WIDTH    multiplier
//   in2        in   WIDTH    multiplicand
//   in_signed  in   1        (MULT_SIGNED_EN only) operands are signed
//   out_valid  out  1        product present on out
//   out_ready  in   1        downstream accepts product
//   out        out  2*WIDTH  product; keeps its value after the transfer
//   busy       out  1        high in BUSY or DONE

module multiplier_shift_add_seq
  import mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
`ifdef MULT_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int ITER    = WIDTH / BITS_PER_CYCLE;
  localparam int COUNT_W = count_w(ITER);
  localparam int OFF_W   = count_w(2 * WIDTH);
  localparam int PW      = 2 * WIDTH;

  if (BITS_PER_CYCLE < 1 || WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("multiplier_shift_add_seq: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  mult_state_t        state;
  logic [WIDTH-1:0]   mplier;   // shifts right so its low bits are always the next ones to retire
  logic [PW-1:0]      mcand;
  logic [PW-1:0]      acc;
  logic [COUNT_W-1:0] count;
  logic               neg;
  logic [PW-1:0]      out_r;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               neg_in;
  logic [OFF_W-1:0]   offset;
  logic [PW-1:0]      psum;
  logic [PW-1:0]      acc_next;
  logic [PW-1:0]      result;
  logic               last;

`ifdef MULT_SIGNED_EN
  // Magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    mag1   = (in_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
    mag2   = (in_signed && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
    neg_in = in_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
  end
`else
  always_comb begin
    mag1   = in1;
    mag2   = in2;
    neg_in = 1'b0;
  end
`endif

  always_comb begin
    offset   = OFF_W'(count) * OFF_W'(BITS_PER_CYCLE);
    acc_next = acc + psum;
    result   = neg ? (~acc_next + 1'b1) : acc_next;
    last     = (count == COUNT_W'(ITER - 1));
  end

  mult_partial_sum #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_partial_sum (
    .bits   (mplier[BITS_PER_CYCLE-1:0]),
    .mcand  (mcand),
    .offset (offset),
    .psum   (psum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      out_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mplier <= mag1;
            mcand  <= {{WIDTH{1'b0}}, mag2};
            acc    <= '0;
            count  <= '0;
            neg    <= neg_in;
            state  <= BUSY;
          end
        end
        BUSY: begin
          mplier <= mplier >> BITS_PER_CYCLE;
          count  <= count + 1'b1;
          if (last) begin
            acc   <= result;
            out_r <= result;
            state <= DONE;
          end else begin
            acc <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = out_r;

endmodule
